alu_seq: RTL
============

# alu_seq

Parametrised multi-cycle ALU for the jrb8 datapath, succeeding the single-cycle combinational ALU. It adds generic operand width, registered results and flags, iterative shifts (one bit per cycle) and an optional shift-add multiplier, all behind a start/busy/done handshake. The control unit issues one operation at a time and stalls on `busy`.

## Interface
- `WIDTH`, 8: operand and result width; legal values are 4 to 32.
- `SHIFT_W`, `$clog2(WIDTH)`: number of `b` bits used as the shift count.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; accepted only when `busy`=0.
- `op`  in  4  opcode, sampled on accept.
- `a`, `b`  in  WIDTH each  operands, sampled on accept; treated as signed for overflow and ASR.
- `carryin`  in  1  carry input for ADC and SBC, sampled on accept.
- `oe`  in  1  output enable, combinational; `result`=0 when low.
- `busy`  out  1  high while an iterative operation runs.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  WIDTH  registered result, gated by `oe`.
- `carryout`, `overout`, `zeroout`  out  1 each  registered flags.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 ADC: a+b+carryin.
  - 2 SUB: a+~b+1.
  - 3 SBC: a+~b+carryin.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~a.
  - 8 SHL, 9 SHR, 10 ASR: shift `a` by `b[SHIFT_W-1:0]`.
  - 11 MUL: low WIDTH bits of a*b, unsigned.
  - 12–15 reserved: `result`=0, all flags 0.
- Arithmetic is computed WIDTH+1 bits wide.
  - `carryout` = bit WIDTH. For SUB/SBC this is carry = not-borrow.
  - `overout` = signed overflow on the MSB of the two adder inputs and the sum, for opcodes 0–3.
- Logic ops, NOT, MUL and reserved ops force `carryout`=0 and `overout`=0.
- Shifts:
  - `carryout` = last bit shifted out; `overout`=0.
  - A count of 0 leaves the result = a with `carryout`=0.
  - SHR fills with 0; ASR fills with a[WIDTH-1].
- `zeroout` = (result==0) for every opcode. It is computed before `oe` gating.
- FSM:
  - IDLE: `start` → RUN if the op is a shift with count>0 or MUL; otherwise → DONE.
  - RUN: a down-counter is loaded with the shift count (shifts) or WIDTH (MUL) and decrements each cycle. When it reaches 1 → DONE.
  - DONE: `done`=1 for one cycle. If `start` is high, the new op is accepted as from IDLE; otherwise → IDLE.
- `result` and flags hold their last values until the next DONE overwrites them.
- `start` while `busy`=1 is ignored. It is not queued.
- Operands are latched on accept. Changing `a`, `b`, `op` or `carryin` during RUN has no effect.
- Reset mid-operation aborts the operation. The FSM returns to IDLE and the partial result is discarded.

## Timing
- Single-cycle ops, and shifts with count 0: accept at edge 0, `done`=1 and `result` valid in the cycle after edge 0.
- Shift by n>0: `busy`=1 for n cycles after accept, `done` in cycle n+1.
- MUL: `busy`=1 for WIDTH cycles, `done` in cycle WIDTH+1.
- `busy` is low in IDLE and DONE, so back-to-back ops have no bubble.
- Reset values: `busy`=0, `done`=0, `result`=0, `carryout`=0, `overout`=0, `zeroout`=0, FSM=IDLE.

## Configuration
- Macro: `ALU_SEQ_MUL_EN`.
- Defined: MUL runs as above through the multiplier sub-module.
- Undefined:
  - The multiplier is not instantiated.
  - Opcode 11 behaves as reserved: single-cycle, `result`=0, flags 0.
  - Area is reduced by the product register and adder.

## Structure
- Package `alu_seq_pkg` holds:
  - the `alu_op_e` 4-bit enum (opcodes 0–11 plus reserved);
  - the `alu_state_e` enum (IDLE, RUN, DONE);
  - the `is_iterative()` function.
- Sub-module `alu_seq_mul`:
  - shift-add multiplier with `load`, `step` and `product` ports;
  - parametrised on WIDTH;
  - instantiated only under `ALU_SEQ_MUL_EN`.
- The top level holds the FSM, counter, adder, logic unit, shift register and flag registers.

## Test plan
All scenarios use WIDTH=8 and `oe`=1 unless stated.
- ADD a=0x7F, b=0x01 → one cycle later `done`; `result`=0x80, `overout`=1, `carryout`=0, `zeroout`=0.
- SUB a=0x05, b=0x05 → `result`=0x00, `zeroout`=1, `carryout`=1. SBC a=0x00, b=0x01, carryin=1 → `result`=0xFF, `carryout`=0.
- ASR a=0x90, b=3 → `busy` for 3 cycles, `done` in cycle 4; `result`=0xF2, `carryout`=0. SHL a=0x81, b=1 → `result`=0x02, `carryout`=1.
- MUL a=13, b=11 (macro defined) → `busy` for 8 cycles, `result`=0x8F. With the macro undefined → `done` after 1 cycle, `result`=0.
- `start` asserted during an MUL RUN → ignored, and the MUL result is unaffected. `start` with ADD held high in the DONE cycle → accepted, and its `done` follows one cycle later.
- Assert `rst` in the 4th RUN cycle of MUL → all outputs 0 and FSM=IDLE; a fresh ADD 2+3 then gives `result`=5.
- `oe`=0 after ADD 2+3 → `result`=0 while `zeroout`=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state types plus the iterative-op classifier for alu_seq
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADC   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SBC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOT   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_ASR   = 4'd10,
        OP_MUL   = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(alu_op_e op, logic cnt_nz, logic mul_en);
        return ((op == OP_SHL || op == OP_SHR || op == OP_ASR) && cnt_nz) ||
               (op == OP_MUL && mul_en);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: shift-add multiplier, one partial product per step, low WIDTH bits kept
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    // product already includes the partial term of the current step, so the
    // caller can capture the final value on the edge of the last step
    assign product = acc + (mplier[0] ? mcand : '0);

    // load the operands, then per step accumulate and shift multiplicand/multiplier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result/flags, iterative shifts and optional MUL (ALU_SEQ_MUL_EN)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overout,
    output logic             zeroout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    alu_state_e       state_q, state_d;
    alu_op_e          op_in, op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q, sh_n, res_q, res_c, y, mul_p, fin_res;
    logic [WIDTH:0]   sum;
    logic             cin, c_c, v_c, z_c, sc_n, accept, iter, fin;
    logic             c_q, v_q, z_q;
    logic [SHIFT_W-1:0] sh_cnt;

    assign op_in  = alu_op_e'(op);
    assign sh_cnt = b[SHIFT_W-1:0];
    assign iter   = is_iterative(op_in, sh_cnt != '0, MUL_EN);
    assign accept = start && state_q != ST_RUN;
    assign fin    = state_q == ST_RUN && cnt_q == CW'(1);

    assign busy     = state_q == ST_RUN;
    assign done     = state_q == ST_DONE;
    assign result   = oe ? res_q : '0;
    assign carryout = c_q;
    assign overout  = v_q;
    assign zeroout  = z_q;

    // WIDTH+1-bit adder shared by ADD/ADC/SUB/SBC; subtraction inverts b
    assign y   = (op_in == OP_SUB || op_in == OP_SBC) ? ~b : b;
    assign cin = op_in == OP_ADD ? 1'b0 : op_in == OP_SUB ? 1'b1 : carryin;
    assign sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    // one-bit shift step on the latched shift register; carry is the bit leaving
    assign sh_n = op_q == OP_SHL ? sh_q << 1 :
                  op_q == OP_SHR ? sh_q >> 1 : {sh_q[M], sh_q[M:1]};
    assign sc_n = op_q == OP_SHL ? sh_q[M] : sh_q[0];

`ifdef ALU_SEQ_MUL_EN
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (accept && op_in == OP_MUL),
        .step    (busy && op_q == OP_MUL),
        .a       (a),
        .b       (b),
        .product (mul_p)
    );
`else
    assign mul_p = '0;
`endif

    assign fin_res = op_q == OP_MUL ? mul_p : sh_n;

    // single-cycle result and flags; shifts reach here only with a zero count
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (op_in)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                res_c = sum[M:0];
                c_c   = sum[WIDTH];
                v_c   = (a[M] == y[M]) && (sum[M] != a[M]);
            end
            OP_AND:                 res_c = a & b;
            OP_OR:                  res_c = a | b;
            OP_XOR:                 res_c = a ^ b;
            OP_NOT:                 res_c = ~a;
            OP_SHL, OP_SHR, OP_ASR: res_c = a;
            default:                res_c = '0;
        endcase
        z_c = res_c == '0 && op_in <= OP_ASR;
    end

    // FSM next state: IDLE and DONE both accept; RUN ends when the counter hits 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  state_d = fin ? ST_DONE : ST_RUN;
            default: state_d = accept ? (iter ? ST_RUN : ST_DONE) : ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // operand latch, iteration counter, shift register and result/flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_ADD;
            cnt_q <= '0;
            sh_q  <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_in;
                sh_q  <= a;
                cnt_q <= op_in == OP_MUL ? CW'(WIDTH) : CW'(sh_cnt);
            end else if (busy) begin
                sh_q  <= sh_n;
                cnt_q <= cnt_q - CW'(1);
            end
            if (accept && !iter) begin
                res_q <= res_c;
                c_q   <= c_c;
                v_q   <= v_c;
                z_q   <= z_c;
            end else if (fin) begin
                res_q <= fin_res;
                c_q   <= op_q != OP_MUL && sc_n;
                v_q   <= 1'b0;
                z_q   <= fin_res == '0;
            end
        end
    end

endmodule
